// File: rtl/display_pkg.sv
// Shared types, colours and helpers for the note grid display path.
package display_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDraw  = 2'd1,
      StClear = 2'd2
   } state_t;

   localparam logic [2:0] BgColour  = 3'b000;
   localparam logic [2:0] HitColour = 3'b111;

   // Lane colours repeat every four lanes.
   function automatic logic [2:0] lane_colour(input int unsigned lane);
      logic [2:0] col;
      unique case (lane % 4)
         0:       col = 3'b010;
         1:       col = 3'b100;
         2:       col = 3'b110;
         default: col = 3'b001;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Nested {row, lane, cy, cx} pixel scan counter; cx innermost, row outermost.
module pixel_scan_counter #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned ROWS   = 8,
   parameter int unsigned CELL_W = 8,
   parameter int unsigned CELL_H = 8,
   localparam int unsigned CxW   = (CELL_W > 1) ? $clog2(CELL_W) : 1,
   localparam int unsigned CyW   = (CELL_H > 1) ? $clog2(CELL_H) : 1,
   localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [RowW-1:0]  row,
   output logic [LaneW-1:0] lane,
   output logic [CyW-1:0]   cy,
   output logic [CxW-1:0]   cx,
   output logic             last
);

   logic [CxW-1:0]   cx_q, cx_d;
   logic [CyW-1:0]   cy_q, cy_d;
   logic [LaneW-1:0] lane_q, lane_d;
   logic [RowW-1:0]  row_q, row_d;
   logic             cx_max, cy_max, lane_max, row_max;

   // Per-field wrap detection.
   always_comb begin
      cx_max   = (cx_q == CxW'(CELL_W - 1));
      cy_max   = (cy_q == CyW'(CELL_H - 1));
      lane_max = (lane_q == LaneW'(LANES - 1));
      row_max  = (row_q == RowW'(ROWS - 1));
      last     = cx_max && cy_max && lane_max && row_max;
   end

   // Ripple increment; every field wraps to 0, so the last pixel returns to the origin.
   always_comb begin
      cx_d   = cx_q;
      cy_d   = cy_q;
      lane_d = lane_q;
      row_d  = row_q;
      if (clr) begin
         cx_d   = '0;
         cy_d   = '0;
         lane_d = '0;
         row_d  = '0;
      end else if (en) begin
         cx_d = cx_max ? '0 : cx_q + 1'b1;
         if (cx_max) begin
            cy_d = cy_max ? '0 : cy_q + 1'b1;
            if (cy_max) begin
               lane_d = lane_max ? '0 : lane_q + 1'b1;
               if (lane_max) begin
                  row_d = row_max ? '0 : row_q + 1'b1;
               end
            end
         end
      end
   end

   // Counter state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cx_q   <= '0;
         cy_q   <= '0;
         lane_q <= '0;
         row_q  <= '0;
      end else begin
         cx_q   <= cx_d;
         cy_q   <= cy_d;
         lane_q <= lane_d;
         row_q  <= row_d;
      end
   end

   assign row  = row_q;
   assign lane = lane_q;
   assign cy   = cy_q;
   assign cx   = cx_q;

endmodule

// File: rtl/note_grid_drawer.sv
// Redraws the snapshotted note grid one pixel per clock on each beat, and
// blanks the grid after reset and at every song end.
module note_grid_drawer
   import display_pkg::*;
#(
   parameter int unsigned LANES    = 4,
   parameter int unsigned ROWS     = 8,
   parameter int unsigned CELL_W   = 8,
   parameter int unsigned CELL_H   = 8,
   parameter int unsigned X_ORIGIN = 64,
   parameter int unsigned Y_ORIGIN = 24,
   localparam int unsigned CxW     = (CELL_W > 1) ? $clog2(CELL_W) : 1,
   localparam int unsigned CyW     = (CELL_H > 1) ? $clog2(CELL_H) : 1,
   localparam int unsigned LaneW   = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  beatIncremented,
   input  logic                  songDone,
   input  logic [LANES*ROWS-1:0] noteGrid,
   output logic                  readyForSong,
   output logic                  plot,
   output logic [7:0]            x,
   output logic [6:0]            y,
   output logic [2:0]            colour,
   output logic                  overrun
);

   state_t                state_q, state_d;
   logic [LANES*ROWS-1:0] grid_q;
   logic                  clear_pending_q, clear_pending_d;
   logic                  song_done_prev_q;
   logic                  overrun_q;

   logic                  scan_clr, scan_en, scan_last;
   logic [RowW-1:0]       row;
   logic [LaneW-1:0]      lane;
   logic [CyW-1:0]        cy;
   logic [CxW-1:0]        cx;

   logic                  is_idle, accept, song_done_rise;
   logic                  active, note_bit;
   logic [31:0]           x_sum, y_sum, bit_idx;
   logic [LANES*ROWS-1:0] grid_shift;

   assign is_idle        = (state_q == StIdle);
   assign accept         = is_idle && beatIncremented;
   assign song_done_rise = songDone && !song_done_prev_q;
   assign scan_clr       = is_idle && (beatIncremented || clear_pending_q);
   assign scan_en        = !is_idle;

   pixel_scan_counter #(
      .LANES  (LANES),
      .ROWS   (ROWS),
      .CELL_W (CELL_W),
      .CELL_H (CELL_H)
   ) u_scan (
      .clock (clock),
      .reset (reset),
      .clr   (scan_clr),
      .en    (scan_en),
      .row   (row),
      .lane  (lane),
      .cy    (cy),
      .cx    (cx),
      .last  (scan_last)
   );

   // State register; reset lands in CLEAR so the grid is blanked first.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StClear;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a beat wins over a pending clear.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (beatIncremented) begin
               state_d = StDraw;
            end else if (clear_pending_q) begin
               state_d = StClear;
            end
         end
         StDraw, StClear: begin
            if (scan_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear request: a fresh songDone edge always wins over consumption.
   always_comb begin
      clear_pending_d = clear_pending_q;
      if (is_idle && !beatIncremented && clear_pending_q) begin
         clear_pending_d = 1'b0;
      end
      if (song_done_rise) begin
         clear_pending_d = 1'b1;
      end
   end

   // Grid snapshot, clear request, songDone history and sticky overrun.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grid_q           <= '0;
         clear_pending_q  <= 1'b0;
         song_done_prev_q <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         if (accept) begin
            grid_q <= noteGrid;
         end
         clear_pending_q  <= clear_pending_d;
         song_done_prev_q <= songDone;
         if (beatIncremented && !is_idle) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // Pixel decode; gated by reset so outputs drop to 0 as soon as reset asserts.
   always_comb begin
      active     = !is_idle && reset;
      x_sum      = X_ORIGIN + 32'(lane) * CELL_W + 32'(cx);
      y_sum      = Y_ORIGIN + 32'(row) * CELL_H + 32'(cy);
      bit_idx    = 32'(row) * LANES + 32'(lane);
      grid_shift = grid_q >> bit_idx;
      note_bit   = (state_q == StDraw) && grid_shift[0];
      plot       = active;
      x          = '0;
      y          = '0;
      colour     = '0;
      if (active) begin
         x = x_sum[7:0];
         y = y_sum[6:0];
         if (note_bit) begin
            colour = lane_colour(32'(lane));
         end else if (32'(row) == ROWS - 1) begin
            colour = HitColour;
         end else begin
            colour = BgColour;
         end
      end
      readyForSong = is_idle;
      overrun      = overrun_q;
   end

endmodule

// File: tb/tb_note_grid_drawer.sv
// Self-checking bench for note_grid_drawer at default parameters.
module tb_note_grid_drawer;

   localparam int N = 2048;

   logic        clock = 1'b0;
   logic        reset;
   logic        beatIncremented;
   logic        songDone;
   logic [31:0] noteGrid;
   logic        readyForSong;
   logic        plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pix_t;

   typedef struct {
      logic [31:0] grid;
      int          lane;
      int          row;
      logic [2:0]  exp_colour;
   } vec_t;

   pix_t       sb[$];
   vec_t       vecs[6];
   logic [2:0] lane_tab[4];
   logic [2:0] cell_col[8][4];

   note_grid_drawer dut (
      .clock           (clock),
      .reset           (reset),
      .beatIncremented (beatIncremented),
      .songDone        (songDone),
      .noteGrid        (noteGrid),
      .readyForSong    (readyForSong),
      .plot            (plot),
      .x               (x),
      .y               (y),
      .colour          (colour),
      .overrun         (overrun)
   );

   always #5 clock = ~clock;

   task automatic check(input bit ok, input string name, input string detail);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // Expected pixel stream for one frame, in scan order.
   task automatic push_frame(input logic [31:0] grid, input bit is_clear);
      for (int i = 0; i < N; i++) begin
         int   cx, cy, ln, rw;
         pix_t p;
         cx = i % 8;
         cy = (i / 8) % 8;
         ln = (i / 64) % 4;
         rw = i / 256;
         p.x = 8'(64 + ln * 8 + cx);
         p.y = 7'(24 + rw * 8 + cy);
         if (!is_clear && grid[rw * 4 + ln]) p.colour = lane_tab[ln];
         else if (rw == 7)                   p.colour = 3'b111;
         else                                p.colour = 3'b000;
         sb.push_back(p);
      end
   endtask

   // Entered just after a posedge with pixel 0 already on the outputs.
   task automatic run_frame(input int beat_at, input int sd_at, input int abort_at);
      for (int i = 0; i < N; i++) begin
         pix_t e;
         @(negedge clock);
         if (sb.size() == 0) begin
            check(1'b0, "scoreboard_empty", $sformatf("pixel %0d has no expected entry", i));
         end else begin
            e = sb.pop_front();
            check(plot === 1'b1 && readyForSong === 1'b0 && x === e.x && y === e.y &&
                  colour === e.colour, "pixel",
                  $sformatf("i=%0d got plot=%b rdy=%b x=%0d y=%0d c=%b, want 1 0 %0d %0d %b",
                            i, plot, readyForSong, x, y, colour, e.x, e.y, e.colour));
         end
         if (i % 64 == 0) cell_col[i / 256][(i / 64) % 4] = colour;
         beatIncremented = (i == beat_at);
         if (i == sd_at) songDone = 1'b1;
         if (i == abort_at) begin
            reset = 1'b0;
            #1;
            check(plot === 1'b0 && x === 8'd0 && y === 7'd0 && colour === 3'd0 &&
                  readyForSong === 1'b0 && overrun === 1'b0, "async_reset",
                  $sformatf("got plot=%b x=%0d y=%0d c=%b rdy=%b ovr=%b, want all 0",
                            plot, x, y, colour, readyForSong, overrun));
            sb.delete();
            return;
         end
      end
      @(posedge clock);
      #1;
      beatIncremented = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check(readyForSong === 1'b1 && plot === 1'b0 && x === 8'd0 && y === 7'd0 &&
            colour === 3'd0, name,
            $sformatf("got rdy=%b plot=%b x=%0d y=%0d c=%b, want 1 0 0 0 0",
                      readyForSong, plot, x, y, colour));
   endtask

   // Drives a one-cycle beat from IDLE; returns with pixel 0 on the outputs.
   task automatic start_beat(input logic [31:0] grid);
      noteGrid = grid;
      push_frame(grid, 1'b0);
      beatIncremented = 1'b1;
      @(posedge clock);
      #1;
      beatIncremented = 1'b0;
      noteGrid = ~grid;
   endtask

   initial begin
      int stray;
      lane_tab[0] = 3'b010;
      lane_tab[1] = 3'b100;
      lane_tab[2] = 3'b110;
      lane_tab[3] = 3'b001;
      vecs[0] = '{grid: 32'h0000_0001, lane: 0, row: 0, exp_colour: 3'b010};
      vecs[1] = '{grid: 32'h8000_0000, lane: 3, row: 7, exp_colour: 3'b001};
      vecs[2] = '{grid: 32'h8000_0000, lane: 2, row: 7, exp_colour: 3'b111};
      vecs[3] = '{grid: 32'hFFFF_FFFF, lane: 1, row: 3, exp_colour: 3'b100};
      vecs[4] = '{grid: 32'h0000_0040, lane: 2, row: 1, exp_colour: 3'b110};
      vecs[5] = '{grid: 32'h0000_0040, lane: 2, row: 0, exp_colour: 3'b000};

      reset = 1'b0;
      beatIncremented = 1'b0;
      songDone = 1'b0;
      noteGrid = '0;
      repeat (3) @(posedge clock);
      #1;
      check(readyForSong === 1'b0 && plot === 1'b0 && colour === 3'd0 && x === 8'd0 &&
            overrun === 1'b0, "reset_state",
            $sformatf("got rdy=%b plot=%b c=%b x=%0d ovr=%b, want 0 0 0 0 0",
                      readyForSong, plot, colour, x, overrun));

      // Clear frame after reset release.
      reset = 1'b1;
      push_frame('0, 1'b1);
      run_frame(-1, -1, -1);
      check_idle("idle_after_reset_clear");

      // Table-driven beat draws.
      foreach (vecs[k]) begin
         start_beat(vecs[k].grid);
         run_frame(-1, -1, -1);
         check_idle("idle_after_draw");
         check(cell_col[vecs[k].row][vecs[k].lane] === vecs[k].exp_colour, "cell_colour",
               $sformatf("vec %0d row %0d lane %0d got %b, want %b", k, vecs[k].row,
                         vecs[k].lane, cell_col[vecs[k].row][vecs[k].lane],
                         vecs[k].exp_colour));
      end

      // Beat during DRAW is ignored but flags overrun.
      check(overrun === 1'b0, "overrun_clear_before", $sformatf("got %b, want 0", overrun));
      start_beat(32'h1234_5678);
      run_frame(100, -1, -1);
      check_idle("idle_after_overrun_frame");
      check(overrun === 1'b1, "overrun_set", $sformatf("got %b, want 1", overrun));

      // songDone rising during DRAW: frame finishes, then one CLEAR.
      start_beat(32'h0F0F_0F0F);
      run_frame(-1, 200, -1);
      check_idle("idle_before_song_clear");
      push_frame('0, 1'b1);
      @(posedge clock);
      #1;
      run_frame(-1, -1, -1);
      check_idle("idle_after_song_clear");
      stray = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (plot !== 1'b0 || readyForSong !== 1'b1) stray++;
      end
      check(stray == 0, "no_retrigger", $sformatf("got %0d busy cycles, want 0", stray));
      check(overrun === 1'b1, "overrun_sticky", $sformatf("got %b, want 1", overrun));

      // songDone edge and beat in the same idle cycle: DRAW then CLEAR.
      songDone = 1'b0;
      @(posedge clock);
      #1;
      songDone = 1'b1;
      start_beat(32'h00F0_0F00);
      run_frame(-1, -1, -1);
      check_idle("idle_between_draw_and_clear");
      push_frame('0, 1'b1);
      @(posedge clock);
      #1;
      run_frame(-1, -1, -1);
      check_idle("idle_after_simultaneous");

      // Reset mid-frame, then CLEAR before ready.
      songDone = 1'b0;
      @(posedge clock);
      #1;
      start_beat(32'hFFFF_0000);
      run_frame(-1, -1, 500);
      repeat (2) @(posedge clock);
      #1;
      check(plot === 1'b0 && readyForSong === 1'b0, "reset_held",
            $sformatf("got plot=%b rdy=%b, want 0 0", plot, readyForSong));
      reset = 1'b1;
      push_frame('0, 1'b1);
      run_frame(-1, -1, -1);
      check_idle("idle_after_abort_clear");
      check(overrun === 1'b0, "overrun_reset", $sformatf("got %b, want 0", overrun));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/note_grid_drawer.md
Name: note_grid_drawer

Overview:
- Display-side consumer of the song sequencer handshake.
- On each `beatIncremented` pulse it snapshots the current note grid and redraws it one pixel per clock to the VGA adapter.
- It deasserts `readyForSong` while drawing and reasserts it when the frame is complete, so the sequencer can advance to the next beat.
- It also blanks the grid after reset and at the end of every song.

Parameters:
- LANES, 4, note lanes (columns); 1..8
- ROWS, 8, visible beats (rows); row 0 at top, row ROWS-1 is the hit row
- CELL_W, 8, cell width in pixels (power of 2)
- CELL_H, 8, cell height in pixels (power of 2)
- X_ORIGIN, 64, x pixel of the grid's top-left corner
- Y_ORIGIN, 24, y pixel of the grid's top-left corner

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- beatIncremented  in  1  one-cycle pulse from sequencer: a new beat is ready to draw
- songDone  in  1  level from sequencer; a rising edge requests a grid clear
- noteGrid  in  LANES*ROWS  note present at bit row*LANES+lane; sampled only on accept
- readyForSong  out  1  high = idle, a new beat may be sent
- plot  out  1  VGA write enable
- x  out  8  VGA x coordinate
- y  out  7  VGA y coordinate
- colour  out  3  VGA colour {R,G,B}
- overrun  out  1  sticky; set when `beatIncremented` arrives while not idle

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=CLEAR, all counters 0, gridReg=0, clearPending=0, overrun=0, songDonePrev=0.
  - Outputs: readyForSong=0, plot=0, x=0, y=0, colour=0.
- States are IDLE, DRAW and CLEAR. After reset is released, CLEAR executes first.
- Frame length is N = LANES*ROWS*CELL_W*CELL_H cycles. Default N = 2048.
- Pixel scan is driven by a nested counter {row, lane, cy, cx}:
  - cx is innermost, row is outermost; each wraps to 0 at its limit.
  - x = X_ORIGIN + lane*CELL_W + cx, computed at width 8; overflow truncates.
  - y = Y_ORIGIN + row*CELL_H + cy, computed at width 7; overflow truncates.
  - `plot`, `x`, `y` and `colour` are combinational decodes of state and counters, with no extra latency.
  - `plot`=1 exactly in DRAW and CLEAR. In IDLE, `plot`=0 and `x`/`y`/`colour` are 0.
- Colour:
  - DRAW, gridReg bit set: LANE_COLOUR[lane].
  - DRAW, bit clear, row==ROWS-1: HIT_COLOUR (3'b111).
  - DRAW, otherwise: BG_COLOUR (3'b000).
  - CLEAR: the same rules with gridReg treated as all-zero.
- IDLE:
  - readyForSong=1.
  - beatIncremented=1 → gridReg<=noteGrid, counters<=0, readyForSong<=0, state<=DRAW.
  - Otherwise, if clearPending → clearPending<=0, counters<=0, readyForSong<=0, state<=CLEAR.
  - A beat takes priority over a pending clear when both occur in the same cycle.
- DRAW / CLEAR:
  - Each cycle plots one pixel.
  - On the last pixel (all counters at max) → counters<=0, readyForSong<=1, state<=IDLE.
  - readyForSong is low for exactly N cycles, starting the cycle after the accept edge.
  - noteGrid changes during DRAW have no effect.
- songDone edge detect: songDonePrev samples songDone every cycle. songDone=1 with songDonePrev=0 sets clearPending in any state. A level held high does not retrigger.
- beatIncremented outside IDLE: ignored, no redraw, overrun<=1. overrun clears only on reset.
- Reset mid-frame: drawing aborts immediately; CLEAR runs after release.

Decomposition:
- Package display_pkg:
  - state encoding (IDLE, DRAW, CLEAR)
  - colour constants BG_COLOUR=3'b000, HIT_COLOUR=3'b111
  - LANE_COLOUR table: lane0 3'b010, lane1 3'b100, lane2 3'b110, lane3 3'b001; lanes ≥4 repeat modulo 4
- Sub-module pixel_scan_counter:
  - Parameterised nested {row, lane, cy, cx} counter with clear/enable inputs and a `last` output.
  - Holds all counter arithmetic; the top level holds the FSM, gridReg and colour decode.

Test Plan:
- Reset release: readyForSong=0; plot=1 for 2048 cycles, all colour=0 except row 7 =3'b111; then readyForSong=1, plot=0.
- Beat draw, noteGrid=32'h0000_0001, pulse beatIncremented: first pixel (x=64,y=24,colour=3'b010) the next cycle; 64 green pixels at x 64..71, y 24..31; readyForSong low exactly 2048 cycles.
- Bit row7/lane3 set (bit 31): pixels x 88..95, y 80..87 have colour 3'b001; other row-7 pixels 3'b111.
- beatIncremented pulse at cycle 100 of a DRAW: frame completes unchanged after 2048 cycles; overrun=1 and stays 1 until reset.
- songDone rises during DRAW: current frame completes, then exactly one CLEAR of 2048 cycles; songDone held high afterwards causes no further clears. songDone rising while idle plus simultaneous beat: DRAW first, then CLEAR.
- Reset asserted at cycle 500 of DRAW: outputs go to 0 asynchronously; after release, a CLEAR runs before readyForSong=1.
